// File: rtl/l1_cache_pkg.sv
// ---------------------------------------------------------------------------
// l1_cache_pkg
//   Shared types for the L1 cache line-age tracking logic.
//   - stale_scan_state_e : state encoding of the stale-line scan FSM
//   - age_t / AGE_MAX    : age counter type and saturation value at the
//                          default 4-bit width
//   - age_max_of()       : saturation value for an arbitrary age width, used
//                          by parametrised users of the tracker
// ---------------------------------------------------------------------------
package l1_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_OFFER = 2'd2
  } stale_scan_state_e;

  localparam int DEF_AGE_W = 4;

  typedef logic [DEF_AGE_W-1:0] age_t;

  localparam age_t AGE_MAX = '1;

  // Largest value representable in an unsigned counter of the given width.
  function automatic int age_max_of(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/stale_way_select.sv
// ---------------------------------------------------------------------------
// stale_way_select
//   Combinational picker for one cache set: finds the lowest-numbered way
//   that is valid and whose age is at or above the stale threshold.
//   A threshold of zero disables detection entirely.
// Ports
//   valid_i      in  NUM_WAYS         valid bit per way
//   age_i        in  NUM_WAYS*AGE_W   packed ages, way w at [w*AGE_W +: AGE_W]
//   threshold_i  in  AGE_W            stale threshold (0 = disabled)
//   hit_o        out 1                some way is stale
//   way_o        out WAY_BITS         lowest stale way (0 when no hit)
//   age_o        out AGE_W            age of that way (0 when no hit)
// ---------------------------------------------------------------------------
module stale_way_select #(
  parameter  int NUM_WAYS = 4,
  parameter  int AGE_W    = 4,
  localparam int WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic [NUM_WAYS-1:0]       valid_i,
  input  logic [NUM_WAYS*AGE_W-1:0] age_i,
  input  logic [AGE_W-1:0]          threshold_i,
  output logic                      hit_o,
  output logic [WAY_BITS-1:0]       way_o,
  output logic [AGE_W-1:0]          age_o
);

  // Walk from the highest way down so the lowest stale way is the last
  // assignment and therefore wins.
  always_comb begin
    hit_o = 1'b0;
    way_o = '0;
    age_o = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if ((threshold_i != '0) && valid_i[w] &&
          (age_i[w*AGE_W +: AGE_W] >= threshold_i)) begin
        hit_o = 1'b1;
        way_o = WAY_BITS'(w);
        age_o = age_i[w*AGE_W +: AGE_W];
      end
    end
  end

endmodule

// File: rtl/stale_scan_tracker.sv
// ---------------------------------------------------------------------------
// stale_scan_tracker
//   Per-line age tracker for the L1 cache. Every (set, way) holds a valid bit
//   and a saturating age counter. Lines age on tick_en, restart on access and
//   drop on invalidate. A round-robin scan walks one set per cycle and offers
//   the lowest stale way of the first stale set it finds to the
//   writeback/eviction logic.
//
// Handshake: stale_valid is asserted in OFFER and stays high, with
//   stale_index/stale_way/stale_age stable, until a cycle in which
//   stale_ready is also high; that cycle is the transfer. The offer is never
//   withdrawn, and nothing but reset drops it.
//
// Ports
//   clk, rst_n                        clock, async active-low reset
//   access_en/_index/_way             hit or fill: age:=0, valid:=1
//   inv_en/_index/_way                invalidate: valid:=0, age:=0
//   tick_en                           age every valid line by one (saturating)
//   scan_en                           let the scan FSM run
//   stale_threshold                   stale when valid && age >= threshold; 0 disables
//   stale_pulse                       a line reached the threshold on the last tick
//   stale_valid/_ready                report channel
//   stale_index/_way/_age             report payload, age as sampled at scan time
//   stale_evcnt                       accepted reports, saturating
// ---------------------------------------------------------------------------
module stale_scan_tracker
  import l1_cache_pkg::*;
#(
  parameter  int NUM_SETS   = 64,
  parameter  int NUM_WAYS   = 4,
  parameter  int AGE_W      = 4,
  parameter  int EVCNT_W    = 16,
  localparam int INDEX_BITS = $clog2(NUM_SETS),
  localparam int WAY_BITS   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  access_en,
  input  logic [INDEX_BITS-1:0] access_index,
  input  logic [WAY_BITS-1:0]   access_way,
  input  logic                  inv_en,
  input  logic [INDEX_BITS-1:0] inv_index,
  input  logic [WAY_BITS-1:0]   inv_way,
  input  logic                  tick_en,
  input  logic                  scan_en,
  input  logic [AGE_W-1:0]      stale_threshold,
  output logic                  stale_pulse,
  output logic                  stale_valid,
  input  logic                  stale_ready,
  output logic [INDEX_BITS-1:0] stale_index,
  output logic [WAY_BITS-1:0]   stale_way,
  output logic [AGE_W-1:0]      stale_age,
  output logic [EVCNT_W-1:0]    stale_evcnt
);

  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(age_max_of(AGE_W));

  // Line state, one packed word per set so a whole set feeds the way picker.
  logic [NUM_WAYS*AGE_W-1:0] age_q   [NUM_SETS];
  logic [NUM_WAYS*AGE_W-1:0] age_d   [NUM_SETS];
  logic [NUM_WAYS-1:0]       valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]       valid_d [NUM_SETS];

  stale_scan_state_e         state_q, state_d;
  logic [INDEX_BITS-1:0]     ptr_q, ptr_d, ptr_next;
  logic [INDEX_BITS-1:0]     rep_index_q, rep_index_d;
  logic [WAY_BITS-1:0]       rep_way_q, rep_way_d;
  logic [AGE_W-1:0]          rep_age_q, rep_age_d;
  logic [EVCNT_W-1:0]        evcnt_q, evcnt_d;
  logic                      pulse_q, pulse_d;

  logic                      accept;
  logic                      sel_hit;
  logic [WAY_BITS-1:0]       sel_way;
  logic [AGE_W-1:0]          sel_age;

  assign accept = (state_q == ST_OFFER) && stale_ready;

  assign ptr_next = (ptr_q == INDEX_BITS'(NUM_SETS - 1)) ? '0
                                                          : ptr_q + INDEX_BITS'(1);

  // Examine the set under the scan pointer.
  stale_way_select #(
    .NUM_WAYS (NUM_WAYS),
    .AGE_W    (AGE_W)
  ) u_way_select (
    .valid_i     (valid_q[ptr_q]),
    .age_i       (age_q[ptr_q]),
    .threshold_i (stale_threshold),
    .hit_o       (sel_hit),
    .way_o       (sel_way),
    .age_o       (sel_age)
  );

  // Per-line update. Priority per line: invalidate, access, clear of the
  // line just accepted by the consumer, tick. Index/way comparisons against
  // the loop constants mean an out-of-range index simply matches no line.
  always_comb begin
    age_d   = age_q;
    valid_d = valid_q;
    pulse_d = 1'b0;
    for (int s = 0; s < NUM_SETS; s++) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (inv_en && (inv_index == INDEX_BITS'(s)) && (inv_way == WAY_BITS'(w))) begin
          valid_d[s][w]              = 1'b0;
          age_d[s][w*AGE_W +: AGE_W] = '0;
        end else if (access_en && (access_index == INDEX_BITS'(s)) &&
                     (access_way == WAY_BITS'(w))) begin
          valid_d[s][w]              = 1'b1;
          age_d[s][w*AGE_W +: AGE_W] = '0;
        end else if (accept && (rep_index_q == INDEX_BITS'(s)) &&
                     (rep_way_q == WAY_BITS'(w))) begin
          age_d[s][w*AGE_W +: AGE_W] = '0;
        end else if (tick_en && valid_q[s][w] &&
                     (age_q[s][w*AGE_W +: AGE_W] != AGE_SAT)) begin
          age_d[s][w*AGE_W +: AGE_W] = age_q[s][w*AGE_W +: AGE_W] + AGE_W'(1);
          // Only the tick that lands exactly on the threshold raises the
          // pulse; a saturated line never increments, so it never re-fires.
          if ((stale_threshold != '0) &&
              ((age_q[s][w*AGE_W +: AGE_W] + AGE_W'(1)) == stale_threshold)) begin
            pulse_d = 1'b1;
          end
        end
      end
    end
  end

  // Scan FSM and report registers.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rep_index_d = rep_index_q;
    rep_way_d   = rep_way_q;
    rep_age_d   = rep_age_q;
    evcnt_d     = evcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (scan_en && (stale_threshold != '0)) begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // Stopping keeps the pointer so a later scan resumes where it left.
        if (!scan_en || (stale_threshold == '0)) begin
          state_d = ST_IDLE;
        end else if (sel_hit) begin
          rep_index_d = ptr_q;
          rep_way_d   = sel_way;
          rep_age_d   = sel_age;
          state_d     = ST_OFFER;
        end else begin
          ptr_d = ptr_next;
        end
      end
      ST_OFFER: begin
        // scan_en and threshold are deliberately not looked at here: an
        // offer, once made, must stay up until it is taken.
        if (stale_ready) begin
          if (evcnt_q != '1) begin
            evcnt_d = evcnt_q + EVCNT_W'(1);
          end
          // Moving past the reported set before rescanning keeps one set
          // from monopolising the channel.
          ptr_d   = ptr_next;
          state_d = scan_en ? ST_SCAN : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        age_q[s]   <= '0;
        valid_q[s] <= '0;
      end
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      rep_index_q <= '0;
      rep_way_q   <= '0;
      rep_age_q   <= '0;
      evcnt_q     <= '0;
      pulse_q     <= 1'b0;
    end else begin
      age_q       <= age_d;
      valid_q     <= valid_d;
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rep_index_q <= rep_index_d;
      rep_way_q   <= rep_way_d;
      rep_age_q   <= rep_age_d;
      evcnt_q     <= evcnt_d;
      pulse_q     <= pulse_d;
    end
  end

  assign stale_pulse = pulse_q;
  assign stale_valid = (state_q == ST_OFFER);
  assign stale_index = rep_index_q;
  assign stale_way   = rep_way_q;
  assign stale_age   = rep_age_q;
  assign stale_evcnt = evcnt_q;

endmodule
